vga_draw_engine: RTL and testbench
==================================

# vga_draw_engine

Parametrised framebuffer draw engine that sits between the processor's draw interface and the write port of the VGA frame buffer. It accepts pixel, rectangle-fill and clear commands over a valid/ready handshake and rasterises them into one framebuffer write per clock. Rectangles are clipped to the framebuffer. Each command can optionally be held until the next frame start, which avoids tearing. Resolution and colour depth are generic, replacing the fixed 160x120x9 single-pixel write path.

## Interface
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels
- COLOR_BITS, 9, bits per pixel
- COORD_BITS, 10, width of command coordinates (unsigned)
- FB_ADDRW, 15, framebuffer address width; must satisfy 2^FB_ADDRW >= FB_WIDTH*FB_HEIGHT

- Fast_Clock  in  1  sole clock, rising edge; the design uses one clock only
- Reset_N  in  1  asynchronous, active-low reset
- Cmd_Valid  in  1  command present
- Cmd_Ready  out  1  engine accepts the command this cycle
- Cmd_Op  in  2  0 = pixel, 1 = rect fill, 2 = clear, 3 = reserved
- Cmd_X0, Cmd_Y0  in  COORD_BITS  start corner (pixel: the target pixel)
- Cmd_X1, Cmd_Y1  in  COORD_BITS  inclusive end corner (rect only)
- Cmd_Color  in  COLOR_BITS  fill colour
- Cmd_Sync  in  1  hold the command until the next Frame_Start
- Frame_Start  in  1  one-cycle pulse at the start of vertical blank
- Abort  in  1  terminate the current command
- FB_Write_Enable  out  1  framebuffer write strobe
- FB_Write_Address  out  FB_ADDRW  y*FB_WIDTH + x
- FB_Write_Data  out  COLOR_BITS  pixel colour
- Busy  out  1  state is not IDLE
- Done  out  1  one-cycle pulse when a command completes
- Error  out  1  one-cycle pulse, coincident with Done, for op 3

## Operation
- FSM states: IDLE, WAIT_SYNC, SETUP, FILL, FINISH.
- IDLE
  - Cmd_Ready = 1.
  - On Cmd_Valid & Cmd_Ready, latch all Cmd_* fields.
  - Go to WAIT_SYNC if Cmd_Sync, else to SETUP.
- WAIT_SYNC
  - Go to SETUP on the first Frame_Start sampled in WAIT_SYNC.
  - A Frame_Start in the accept cycle itself is ignored.
- SETUP (one cycle)
  - Pixel: xs = xe = X0, ys = ye = Y0.
  - Clear: xs = 0, xe = FB_WIDTH-1, ys = 0, ye = FB_HEIGHT-1.
  - Rect: xs = X0, ys = Y0, xe = min(X1, FB_WIDTH-1), ye = min(Y1, FB_HEIGHT-1).
  - The region is empty if X0 > X1, Y0 > Y1, X0 >= FB_WIDTH or Y0 >= FB_HEIGHT (a pixel op uses the last two tests only).
  - Empty region or op 3: go to FINISH with no writes.
  - Otherwise: row_base = ys*FB_WIDTH (constant multiply), go to FILL.
- FILL
  - One write per cycle at (x, y), raster order: x increments to xe, then x = xs and y increments.
  - Address is row_base + x; row_base += FB_WIDTH on each row change. No multiply inside FILL.
  - Go to FINISH after the write at (xe, ye).
- FINISH (one cycle)
  - Done = 1; Error = 1 if op was 3. Next state IDLE.
- Abort
  - Sampled high in WAIT_SYNC, SETUP or FILL: go to IDLE next cycle.
  - FB_Write_Enable = 0 from that edge on; no Done pulse.
  - Ignored in IDLE and FINISH.
- Arithmetic
  - Coordinates are unsigned; comparisons are zero-extended.
  - The address adder is FB_ADDRW+1 bits wide, truncated to FB_ADDRW.
  - Cmd_Color is truncated or extended to COLOR_BITS by port width only.

## Timing
- All outputs are registered except Busy, which is decoded from the state register.
- Reset (Reset_N low, asynchronous)
  - State = IDLE.
  - Cmd_Ready, FB_Write_Enable, FB_Write_Address, FB_Write_Data, Done, Error = 0.
  - Cmd_Ready rises at the first rising edge after Reset_N deasserts.
  - Reset mid-FILL drops FB_Write_Enable immediately; the command is lost with no Done.
- Command accepted at edge N, no sync, w*h non-empty pixels
  - SETUP in cycle N+1.
  - Writes on cycles N+2 .. N+1+w*h.
  - Done on cycle N+2+w*h.
  - Cmd_Ready high again on cycle N+3+w*h.
- Empty region or op 3: Done on cycle N+2, with no FB_Write_Enable.
- Sync: SETUP in the cycle after the Frame_Start is sampled; the remaining cycles follow as above.
- Cmd_Ready is low in every non-IDLE state, so back-to-back commands have a 3-cycle minimum gap.
- FB_Write_Address and FB_Write_Data hold their last value when FB_Write_Enable = 0.

## Test plan
- Reset, then pixel op X0=5, Y0=2, colour 0x1FF -> single write at address 325 with data 0x1FF on cycle N+2, Done on N+3, Cmd_Ready on N+4.
- Rect X0=158, Y0=118, X1=200, Y1=130 -> clipped to 2x2: addresses 19038, 19039, 19198, 19199, in that order; then Done.
- Rect with X0=10, X1=5, and a pixel at X0=160 -> no writes, Done on N+2 each time; op 3 -> Done and Error together on N+2.
- Clear with Cmd_Sync=1 and Frame_Start 40 cycles after accept -> no writes before Frame_Start, then 19200 consecutive writes at addresses 0..19199, then Done.
- Abort asserted in the 10th FILL cycle of a 20x20 rect -> writes stop at the next edge, no Done, Cmd_Ready returns, and a following pixel command executes normally.
- Reset_N pulsed low mid-FILL, plus a FB_WIDTH=320, FB_HEIGHT=240, FB_ADDRW=17 build -> all outputs 0 asynchronously; in the large build, pixel (319,239) writes address 76799.

Source files
------------

// File: rtl/vga_draw_engine.sv
// Rasterises pixel / rect-fill / clear commands into one framebuffer write per clock.
// Latency: 1 setup cycle + w*h writes + 1 done cycle; Cmd_Ready is high only in IDLE.
module vga_draw_engine #(
    parameter int FB_WIDTH   = 160,
    parameter int FB_HEIGHT  = 120,
    parameter int COLOR_BITS = 9,
    parameter int COORD_BITS = 10,
    parameter int FB_ADDRW   = 15
) (
    input  logic                  Fast_Clock,
    input  logic                  Reset_N,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic [1:0]            Cmd_Op,
    input  logic [COORD_BITS-1:0] Cmd_X0,
    input  logic [COORD_BITS-1:0] Cmd_Y0,
    input  logic [COORD_BITS-1:0] Cmd_X1,
    input  logic [COORD_BITS-1:0] Cmd_Y1,
    input  logic [COLOR_BITS-1:0] Cmd_Color,
    input  logic                  Cmd_Sync,
    input  logic                  Frame_Start,
    input  logic                  Abort,
    output logic                  FB_Write_Enable,
    output logic [FB_ADDRW-1:0]   FB_Write_Address,
    output logic [COLOR_BITS-1:0] FB_Write_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int AW1 = FB_ADDRW + 1;
    localparam logic [1:0] OP_PIXEL = 2'd0;
    localparam logic [1:0] OP_RECT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;
    localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(FB_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(FB_HEIGHT - 1);
    localparam logic [AW1-1:0] ROW_STEP = AW1'(FB_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SYNC, S_SETUP, S_FILL, S_FINISH} state_t;

    state_t                  state, state_n;
    logic [1:0]              op_q;
    logic [COORD_BITS-1:0]   x0_q, y0_q, x1_q, y1_q;
    logic [COLOR_BITS-1:0]   color_q;
    logic [COORD_BITS-1:0]   xs_q, xe_q, ye_q, x_q, y_q;
    logic [COORD_BITS-1:0]   x_n, y_n;
    logic [FB_ADDRW-1:0]     row_base_q, rb_n;
    logic [COORD_BITS-1:0]   su_xs, su_ys, su_xe, su_ye;
    logic                    su_empty, x0_off, y0_off;
    logic                    accept, last_col;
    logic [AW1-1:0]          addr_sum;

    assign accept   = (state == S_IDLE) && Cmd_Valid && Cmd_Ready;
    assign last_col = (x_q == xe_q);
    assign Busy     = (state != S_IDLE);
    assign x0_off   = 32'(x0_q) >= 32'(FB_WIDTH);
    assign y0_off   = 32'(y0_q) >= 32'(FB_HEIGHT);

    // Region bounds and emptiness, evaluated from the latched command during SETUP.
    always_comb begin
        su_xs    = x0_q;
        su_ys    = y0_q;
        su_xe    = x0_q;
        su_ye    = y0_q;
        su_empty = 1'b0;
        case (op_q)
            OP_PIXEL: su_empty = x0_off || y0_off;
            OP_RECT: begin
                su_xe    = (x1_q > X_MAX) ? X_MAX : x1_q;
                su_ye    = (y1_q > Y_MAX) ? Y_MAX : y1_q;
                su_empty = (x0_q > x1_q) || (y0_q > y1_q) || x0_off || y0_off;
            end
            OP_CLEAR: begin
                su_xs = '0;
                su_ys = '0;
                su_xe = X_MAX;
                su_ye = Y_MAX;
            end
            default: su_empty = 1'b1;
        endcase
    end

    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        rb_n    = row_base_q;
        case (state)
            S_IDLE: if (accept) state_n = Cmd_Sync ? S_WAIT_SYNC : S_SETUP;
            S_WAIT_SYNC: begin
                if (Abort)            state_n = S_IDLE;
                else if (Frame_Start) state_n = S_SETUP;
            end
            S_SETUP: begin
                if (Abort)         state_n = S_IDLE;
                else if (su_empty) state_n = S_FINISH;
                else begin
                    state_n = S_FILL;
                    x_n     = su_xs;
                    y_n     = su_ys;
                    rb_n    = FB_ADDRW'(AW1'(su_ys) * ROW_STEP);
                end
            end
            S_FILL: begin
                if (Abort)                          state_n = S_IDLE;
                else if (last_col && y_q == ye_q)   state_n = S_FINISH;
                else if (last_col) begin
                    x_n  = xs_q;
                    y_n  = y_q + COORD_BITS'(1);
                    rb_n = FB_ADDRW'(AW1'(row_base_q) + ROW_STEP);
                end else begin
                    x_n = x_q + COORD_BITS'(1);
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    assign addr_sum = AW1'(rb_n) + AW1'(x_n);

    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            op_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (accept) begin
            op_q    <= Cmd_Op;
            x0_q    <= Cmd_X0;
            y0_q    <= Cmd_Y0;
            x1_q    <= Cmd_X1;
            y1_q    <= Cmd_Y1;
            color_q <= Cmd_Color;
        end
    end

    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            xs_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
        end else begin
            if (state == S_SETUP) begin
                xs_q <= su_xs;
                xe_q <= su_xe;
                ye_q <= su_ye;
            end
            x_q        <= x_n;
            y_q        <= y_n;
            row_base_q <= rb_n;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            Cmd_Ready        <= 1'b0;
            FB_Write_Enable  <= 1'b0;
            FB_Write_Address <= '0;
            FB_Write_Data    <= '0;
            Done             <= 1'b0;
            Error            <= 1'b0;
        end else begin
            Cmd_Ready       <= (state_n == S_IDLE);
            FB_Write_Enable <= (state_n == S_FILL);
            Done            <= (state_n == S_FINISH);
            Error           <= (state_n == S_FINISH) && (op_q == OP_RSVD);
            if (state_n == S_FILL) begin
                FB_Write_Address <= addr_sum[FB_ADDRW-1:0];
                FB_Write_Data    <= color_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_draw_engine.sv
// Directed + randomized bench for vga_draw_engine, checked against a region-enumeration model.
module tb_vga_draw_engine;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int LW = 320;
    localparam int LH = 240;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, lg_valid;
    logic [1:0]  cmd_op;
    logic [9:0]  x0, y0, x1, y1;
    logic [8:0]  color;
    logic        cmd_sync, frame_start, abort_i;
    logic        ready, we, busy, done, err;
    logic [14:0] addr;
    logic [8:0]  data;
    logic        lg_ready, lg_we, lg_busy, lg_done, lg_err;
    logic [16:0] lg_addr;
    logic [8:0]  lg_data;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    bit exp_err;

    always #5 clk = ~clk;

    vga_draw_engine dut (
        .Fast_Clock(clk), .Reset_N(rst_n), .Cmd_Valid(cmd_valid), .Cmd_Ready(ready),
        .Cmd_Op(cmd_op), .Cmd_X0(x0), .Cmd_Y0(y0), .Cmd_X1(x1), .Cmd_Y1(y1),
        .Cmd_Color(color), .Cmd_Sync(cmd_sync), .Frame_Start(frame_start), .Abort(abort_i),
        .FB_Write_Enable(we), .FB_Write_Address(addr), .FB_Write_Data(data),
        .Busy(busy), .Done(done), .Error(err)
    );

    vga_draw_engine #(.FB_WIDTH(LW), .FB_HEIGHT(LH), .FB_ADDRW(17)) dut_lg (
        .Fast_Clock(clk), .Reset_N(rst_n), .Cmd_Valid(lg_valid), .Cmd_Ready(lg_ready),
        .Cmd_Op(cmd_op), .Cmd_X0(x0), .Cmd_Y0(y0), .Cmd_X1(x1), .Cmd_Y1(y1),
        .Cmd_Color(color), .Cmd_Sync(cmd_sync), .Frame_Start(frame_start), .Abort(abort_i),
        .FB_Write_Enable(lg_we), .FB_Write_Address(lg_addr), .FB_Write_Data(lg_data),
        .Busy(lg_busy), .Done(lg_done), .Error(lg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: enumerate the clipped region in raster order as y*W+x.
    function automatic void build_exp(input int op, input int ax0, input int ay0,
                                      input int ax1, input int ay1);
        int xs, xe, ys, ye;
        bit empty;
        exp_q.delete();
        exp_err = (op == 3);
        xs = ax0; ys = ay0; xe = ax0; ye = ay0; empty = 1'b0;
        if (op == 0) begin
            empty = (ax0 >= W) || (ay0 >= H);
        end else if (op == 1) begin
            xe = (ax1 < W) ? ax1 : W - 1;
            ye = (ay1 < H) ? ay1 : H - 1;
            empty = (ax0 > ax1) || (ay0 > ay1) || (ax0 >= W) || (ay0 >= H);
        end else if (op == 2) begin
            xs = 0; ys = 0; xe = W - 1; ye = H - 1;
        end else begin
            empty = 1'b1;
        end
        if (!empty)
            for (int y = ys; y <= ye; y++)
                for (int x = xs; x <= xe; x++)
                    exp_q.push_back(y * W + x);
    endfunction

    task automatic drive(input int op, input int ax0, input int ay0, input int ax1,
                         input int ay1, input int col, input bit sync);
        cmd_op = 2'(op);
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
        color = 9'(col);
        cmd_sync = sync;
    endtask

    // Entered at a negedge with the engine idle; checks every cycle through Cmd_Ready return.
    task automatic run_cmd(input int op, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int col, input bit sync, input int fs_delay);
        build_exp(op, ax0, ay0, ax1, ay1);
        chk("ready_idle", 32'(ready), 1);
        drive(op, ax0, ay0, ax1, ay1, col, sync);
        frame_start = sync;  // a Frame_Start in the accept cycle must be ignored
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; frame_start = 1'b0; cmd_sync = 1'b0;
        chk("ready_low", 32'(ready), 0);
        chk("busy", 32'(busy), 1);
        chk("we_first", 32'(we), 0);
        if (sync) begin
            for (int i = 0; i < fs_delay; i++) begin
                @(negedge clk);
                chk("we_wait", 32'(we), 0);
                chk("done_wait", 32'(done), 0);
            end
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            chk("we_setup_sync", 32'(we), 0);
        end
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk("we", 32'(we), 1);
            chk("addr", 32'(addr), 32'(exp_q[i]));
            chk("data", 32'(data), 32'(col));
            chk("done_fill", 32'(done), 0);
        end
        @(negedge clk);
        chk("done", 32'(done), 1);
        chk("error", 32'(err), 32'(exp_err));
        chk("we_finish", 32'(we), 0);
        if (exp_q.size() > 0) chk("addr_hold", 32'(addr), 32'(exp_q[exp_q.size()-1]));
        @(negedge clk);
        chk("ready_back", 32'(ready), 1);
        chk("busy_back", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
    endtask

    initial begin
        int op, ax0, ay0, ax1, ay1;
        rst_n = 1'b1; cmd_valid = 1'b0; lg_valid = 1'b0; frame_start = 1'b0; abort_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(ready), 0);
        @(negedge clk);
        chk("ready_after_edge", 32'(ready), 1);

        run_cmd(0, 5, 2, 0, 0, 'h1FF, 1'b0, 0);
        run_cmd(1, 158, 118, 200, 130, 'h0C3, 1'b0, 0);
        run_cmd(1, 10, 20, 5, 25, 'h011, 1'b0, 0);
        run_cmd(0, 160, 5, 0, 0, 'h022, 1'b0, 0);
        run_cmd(3, 1, 1, 2, 2, 'h033, 1'b0, 0);
        run_cmd(2, 0, 0, 0, 0, 'h0AA, 1'b1, 39);

        // Abort during the 10th write of a 20x20 fill.
        build_exp(1, 20, 30, 39, 49);
        drive(1, 20, 30, 39, 49, 'h155, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_we", 32'(we), 1);
            chk("abort_addr", 32'(addr), 32'(exp_q[i]));
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_we_off", 32'(we), 0);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(ready), 1);
        @(negedge clk);
        chk("abort_no_done2", 32'(done), 0);
        chk("abort_we_off2", 32'(we), 0);
        run_cmd(0, 7, 9, 0, 0, 'h0F0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: op = 0;
                1: op = 1;
                default: op = 3;
            endcase
            ax0 = $urandom_range(0, 170);
            ay0 = $urandom_range(0, 125);
            ax1 = (ax0 >= 140 && $urandom_range(0, 2) == 0) ? 1023 : ax0 + $urandom_range(0, 6) - 1;
            ay1 = (ay0 >= 110 && $urandom_range(0, 2) == 0) ? 1023 : ay0 + $urandom_range(0, 5) - 1;
            if (ax1 < 0) ax1 = 0;
            if (ay1 < 0) ay1 = 0;
            run_cmd(op, ax0, ay0, ax1, ay1, $urandom_range(0, 511),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4));
        end

        // Large build: pixel at the far corner.
        drive(0, LW - 1, LH - 1, 0, 0, 'h155, 1'b0);
        chk("lg_ready_idle", 32'(lg_ready), 1);
        lg_valid = 1'b1;
        @(negedge clk);
        lg_valid = 1'b0;
        chk("lg_busy", 32'(lg_busy), 1);
        chk("lg_we_setup", 32'(lg_we), 0);
        @(negedge clk);
        chk("lg_we", 32'(lg_we), 1);
        chk("lg_addr", 32'(lg_addr), 32'((LH - 1) * LW + (LW - 1)));
        chk("lg_data", 32'(lg_data), 'h155);
        @(negedge clk);
        chk("lg_done", 32'(lg_done), 1);
        chk("lg_err", 32'(lg_err), 0);
        chk("lg_we_off", 32'(lg_we), 0);
        @(negedge clk);
        chk("lg_ready_back", 32'(lg_ready), 1);
        chk("lg_busy_back", 32'(lg_busy), 0);

        // Asynchronous reset in the middle of a fill.
        drive(1, 0, 0, 30, 5, 'h1AB, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_we", 32'(we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 0);
        chk("arst_addr", 32'(addr), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_lg_ready", 32'(lg_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_ready_hold", 32'(ready), 0);
        @(negedge clk);
        chk("arst_ready_up", 32'(ready), 1);
        chk("arst_no_done", 32'(done), 0);
        chk("arst_we_idle", 32'(we), 0);
        run_cmd(0, 159, 119, 0, 0, 'h001, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
